// File: rtl/mixer_prims.sv
// Audio mixer datapath primitives: a 24-bit sample ring buffer, a sticky
// pop-request latch and a fixed-latency signed Q8.24 scale multiplier.
// The three functions share clk/rst only; none observes the others' state.
//
// Strobe semantics (all inputs are level-sampled on the rising clk edge,
// there is no ready/backpressure anywhere): rb_we_i and rb_pop_i each act on
// every edge they are high, pl_pop_i/pl_ack_pop_i are likewise per-edge
// requests, and the multiplier accepts a new operand pair on every edge.
module mixer_prims #(
   parameter int RB_LEN       = 4,
   parameter int RB_LEN_LOG2  = 2,
   parameter int MULT_LATENCY = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   // ring buffer
   input  logic [23:0]            rb_data_i,
   input  logic                   rb_we_i,
   input  logic                   rb_pop_i,
   input  logic [RB_LEN_LOG2-1:0] rb_offset_i,
   output logic [23:0]            rb_data_o,
   // pop latch
   input  logic                   pl_pop_i,
   input  logic                   pl_ack_pop_i,
   output logic                   pl_pop_latched_o,
   // multiplier
   input  logic [23:0]            mp_mpcand_i,
   input  logic [31:0]            mp_scale_i,
   output logic [31:0]            mp_mprod_o
);

   // Operand capture takes one edge and the product register another, so
   // the remaining latency is spent in plain delay stages after the product.
   localparam int PIPE_LEN = MULT_LATENCY - 1;

   localparam logic [RB_LEN_LOG2-1:0] PTR_ONE = 1;

   // ------------------------------------------------------------------
   // Ring buffer
   // ------------------------------------------------------------------
   logic [23:0]            mem_q [RB_LEN];
   logic [RB_LEN_LOG2-1:0] wptr_q, wptr_d;
   logic [RB_LEN_LOG2-1:0] rptr_q, rptr_d;
   logic [RB_LEN_LOG2-1:0] rd_idx;

   // Pointer next-state: each strobe advances its own pointer, wrapping freely.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (rb_we_i)  wptr_d = wptr_q + PTR_ONE;
      if (rb_pop_i) rptr_d = rptr_q + PTR_ONE;
   end

   // Pointer and storage registers; no full/empty protection, overwrite is silent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < RB_LEN; i++) mem_q[i] <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         if (rb_we_i) mem_q[wptr_q] <= rb_data_i;
      end
   end

   // Combinational read relative to the read pointer; index wraps by truncation.
   always_comb begin
      rd_idx    = rptr_q + rb_offset_i;
      rb_data_o = mem_q[rd_idx];
   end

   // ------------------------------------------------------------------
   // Pop latch
   // ------------------------------------------------------------------
   logic pop_latched_q, pop_latched_d;

   // Set wins over clear so a request arriving with an ack is never lost.
   always_comb begin
      pop_latched_d = pop_latched_q;
      if (pl_pop_i)          pop_latched_d = 1'b1;
      else if (pl_ack_pop_i) pop_latched_d = 1'b0;
   end

   // Latch state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pop_latched_q <= 1'b0;
      else     pop_latched_q <= pop_latched_d;
   end

   assign pl_pop_latched_o = pop_latched_q;

   // ------------------------------------------------------------------
   // Multiplier
   // ------------------------------------------------------------------
   logic signed [23:0] mpcand_q;
   logic signed [31:0] scale_q;
   logic signed [55:0] full_d;
   logic [31:0]        pipe_q [PIPE_LEN];

   // Full-precision signed product; both operands sign-extended to 56 bits.
   always_comb begin
      full_d = 56'(mpcand_q) * 56'(scale_q);
   end

   // Operand capture, product truncation (>>24, no rounding) and delay line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mpcand_q <= '0;
         scale_q  <= '0;
         for (int i = 0; i < PIPE_LEN; i++) pipe_q[i] <= '0;
      end else begin
         mpcand_q  <= mp_mpcand_i;
         scale_q   <= mp_scale_i;
         pipe_q[0] <= full_d[55:24];
         for (int i = 1; i < PIPE_LEN; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign mp_mprod_o = pipe_q[PIPE_LEN-1];

endmodule

// File: tb/tb_mixer_prims.sv
// Directed bench for mixer_prims: reset, ring buffer ordering/wrap,
// pop latch priority, and multiplier values, latency and throughput.
module tb_mixer_prims;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] rb_data_i = '0;
   logic        rb_we_i = 1'b0;
   logic        rb_pop_i = 1'b0;
   logic [1:0]  rb_offset_i = '0;
   logic [23:0] rb_data_o;
   logic        pl_pop_i = 1'b0;
   logic        pl_ack_pop_i = 1'b0;
   logic        pl_pop_latched_o;
   logic [23:0] mp_mpcand_i = '0;
   logic [31:0] mp_scale_i = '0;
   logic [31:0] mp_mprod_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];

   typedef struct {
      logic [23:0] mpcand;
      logic [31:0] scale;
      logic [31:0] prod;
   } mvec_t;

   mvec_t mv [7];

   mixer_prims #(.RB_LEN(4), .RB_LEN_LOG2(2), .MULT_LATENCY(6)) dut (
      .clk              (clk),
      .rst              (rst),
      .rb_data_i        (rb_data_i),
      .rb_we_i          (rb_we_i),
      .rb_pop_i         (rb_pop_i),
      .rb_offset_i      (rb_offset_i),
      .rb_data_o        (rb_data_o),
      .pl_pop_i         (pl_pop_i),
      .pl_ack_pop_i     (pl_ack_pop_i),
      .pl_pop_latched_o (pl_pop_latched_o),
      .mp_mpcand_i      (mp_mpcand_i),
      .mp_scale_i       (mp_scale_i),
      .mp_mprod_o       (mp_mprod_o)
   );

   // clock
   always #5 clk = ~clk;

   // advance one rising edge and settle 1 ns past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // asynchronous reset pulse, asserted between edges
   task automatic do_reset();
      rst = 1'b1;
      #1;
      tick();
      rst = 1'b0;
   endtask

   task automatic rb_write(input logic [23:0] d);
      rb_data_i = d;
      rb_we_i   = 1'b1;
      tick();
      rb_we_i   = 1'b0;
   endtask

   task automatic rb_read(input string name, input logic [1:0] off, input logic [23:0] exp);
      rb_offset_i = off;
      #1;
      check(name, {8'h0, rb_data_o}, {8'h0, exp});
   endtask

   initial begin
      mv[0] = '{24'h7FFFFF, 32'h01000000, 32'h007FFFFF};
      mv[1] = '{24'h800000, 32'h01000000, 32'hFF800000};
      mv[2] = '{24'h000100, 32'h00800000, 32'h00000080};
      mv[3] = '{24'h7FFFFF, 32'h02000000, 32'h00FFFFFE};
      mv[4] = '{24'h000003, 32'hFF000000, 32'hFFFFFFFD};
      mv[5] = '{24'hFFFFFF, 32'h00800000, 32'hFFFFFFFF};
      mv[6] = '{24'h000001, 32'h00000001, 32'h00000000};

      // ---------- reset without a clock edge, after some activity ----------
      tick();
      rb_write(24'hABCDEF);
      pl_pop_i = 1'b1; mp_mpcand_i = 24'h7FFFFF; mp_scale_i = 32'h01000000;
      tick();
      pl_pop_i = 1'b0; mp_mpcand_i = '0; mp_scale_i = '0;
      repeat (6) tick();
      rst = 1'b1;
      #1;
      check("rst_rb_data", {8'h0, rb_data_o}, 32'h0);
      check("rst_pl_flag", {31'h0, pl_pop_latched_o}, 32'h0);
      check("rst_mprod", mp_mprod_o, 32'h0);
      tick();
      rst = 1'b0;

      // ---------- ring buffer order ----------
      rb_offset_i = 2'd0;
      rb_write(24'h000001);
      check("rb_visible_next_cycle", {8'h0, rb_data_o}, 32'h1);
      rb_write(24'h000002);
      rb_write(24'h000003);
      rb_read("rb_off0", 2'd0, 24'h000001);
      rb_read("rb_off2", 2'd2, 24'h000003);
      rb_read("rb_off3_unwritten", 2'd3, 24'h000000);
      rb_pop_i = 1'b1; tick(); rb_pop_i = 1'b0;
      rb_read("rb_pop_off0", 2'd0, 24'h000002);
      rb_read("rb_pop_off1", 2'd1, 24'h000003);
      rb_read("rb_pop_off3_wrap", 2'd3, 24'h000001);

      // ---------- ring buffer overwrite wrap ----------
      do_reset();
      for (int i = 0; i < 5; i++) rb_write(24'h000010 + 24'(i));
      rb_read("rb_wrap_slot0", 2'd0, 24'h000014);
      rb_read("rb_wrap_slot1", 2'd1, 24'h000011);
      rb_read("rb_wrap_slot3", 2'd3, 24'h000013);

      // ---------- simultaneous write and pop (wptr=1, rptr=0) ----------
      rb_data_i = 24'h000020; rb_we_i = 1'b1; rb_pop_i = 1'b1;
      tick();
      rb_we_i = 1'b0; rb_pop_i = 1'b0;
      rb_read("rb_sim_off0", 2'd0, 24'h000020);
      rb_read("rb_sim_off1", 2'd1, 24'h000012);
      rb_write(24'h000021);
      rb_read("rb_sim_after_write", 2'd1, 24'h000021);
      rb_pop_i = 1'b1; repeat (3) tick(); rb_pop_i = 1'b0;
      rb_read("rb_pop_past_wrap", 2'd0, 24'h000014);

      // reset mid-operation loses contents
      rst = 1'b1;
      #1;
      rb_read("rb_mid_reset", 2'd1, 24'h000000);
      tick();
      rst = 1'b0;

      // ---------- pop latch ----------
      check("pl_idle", {31'h0, pl_pop_latched_o}, 32'h0);
      pl_pop_i = 1'b1; tick(); pl_pop_i = 1'b0;
      check("pl_set", {31'h0, pl_pop_latched_o}, 32'h1);
      tick();
      check("pl_sticky", {31'h0, pl_pop_latched_o}, 32'h1);
      pl_ack_pop_i = 1'b1; tick(); pl_ack_pop_i = 1'b0;
      check("pl_ack_clear", {31'h0, pl_pop_latched_o}, 32'h0);
      tick();
      check("pl_stays_clear", {31'h0, pl_pop_latched_o}, 32'h0);
      pl_pop_i = 1'b1; pl_ack_pop_i = 1'b1; tick();
      pl_pop_i = 1'b0; pl_ack_pop_i = 1'b0;
      check("pl_pop_wins", {31'h0, pl_pop_latched_o}, 32'h1);
      pl_ack_pop_i = 1'b1; tick(); pl_ack_pop_i = 1'b0;

      // ---------- multiplier latency (pipeline holds zeros) ----------
      do_reset();
      mp_mpcand_i = 24'h7FFFFF; mp_scale_i = 32'h01000000;
      for (int e = 1; e <= 7; e++) begin
         tick();
         mp_mpcand_i = '0; mp_scale_i = '0;
         if (e == 6) check("mp_latency_hit", mp_mprod_o, 32'h007FFFFF);
         else        check($sformatf("mp_latency_edge%0d", e), mp_mprod_o, 32'h0);
      end

      // ---------- multiplier table, back to back ----------
      for (int c = 0; c < 7 + 5; c++) begin
         if (c < 7) begin
            mp_mpcand_i = mv[c].mpcand;
            mp_scale_i  = mv[c].scale;
            exp_q.push_back(mv[c].prod);
         end else begin
            mp_mpcand_i = '0;
            mp_scale_i  = '0;
         end
         tick();
         if (c >= 5) check($sformatf("mp_vec%0d", c - 5), mp_mprod_o, exp_q.pop_front());
      end
      check("mp_queue_drained", 32'(exp_q.size()), 32'h0);

      // ---------- reset clears in-flight products ----------
      mp_mpcand_i = 24'h7FFFFF; mp_scale_i = 32'h01000000;
      tick();
      mp_mpcand_i = '0; mp_scale_i = '0;
      tick();
      rst = 1'b1;
      #1;
      check("mp_mid_reset", mp_mprod_o, 32'h0);
      tick();
      rst = 1'b0;
      for (int e = 0; e < 6; e++) begin
         tick();
         check($sformatf("mp_flushed%0d", e), mp_mprod_o, 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // hard time limit so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
